// File: rtl/pa_risc_dmem_responder.sv
// rtl/pa_risc_dmem_responder.sv - big-endian byte-addressed data memory with programmable response latency
// Optional statistics counters enabled by defining DMEM_RESPONDER_STATS_EN.
module pa_risc_dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       o_stat_loads,
  output logic [15:0]       o_stat_stores,
  output logic [15:0]       o_stat_errs
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [7:0]        r_mem [DEPTH];

  logic              w_accept;
  logic              w_exec;
  logic [1:0]        w_nbytes_m1;
  logic [ADDR_W+1:0] w_last;
  logic              w_err;
  logic [ADDR_W-1:0] w_a1;
  logic [ADDR_W-1:0] w_a2;
  logic [ADDR_W-1:0] w_a3;
  logic [7:0]        w_b0;
  logic [7:0]        w_b1;
  logic [7:0]        w_b2;
  logic [7:0]        w_b3;
  logic [31:0]       w_rdata;

  assign w_accept    = (r_state == S_IDLE) && i_req_valid;
  assign w_exec      = (r_state == S_EXEC);
  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_req_valid) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_EXEC;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
    end else if (w_accept) begin
      r_cnt    <= WAIT_LOAD;
      r_we     <= i_req_we;
      r_size   <= i_req_size;
      r_signed <= i_req_signed;
      r_addr   <= i_req_addr;
      r_wdata  <= i_req_wdata;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_nbytes_m1 = 2'd0;
    case (r_size)
      2'b01:   w_nbytes_m1 = 2'd1;
      2'b10:   w_nbytes_m1 = 2'd3;
      default: w_nbytes_m1 = 2'd0;
    endcase
  end

  // Widened by two bits so an access running past the top of the address space is still caught.
  assign w_last = {2'b00, r_addr} + {{ADDR_W{1'b0}}, w_nbytes_m1};
  assign w_err  = (r_size == 2'b11)
               || (r_size == 2'b01 && r_addr[0])
               || (r_size == 2'b10 && r_addr[1:0] != 2'b00)
               || (32'(w_last) >= DEPTH);

  assign w_a1 = r_addr + ADDR_W'(1);
  assign w_a2 = r_addr + ADDR_W'(2);
  assign w_a3 = r_addr + ADDR_W'(3);
  assign w_b0 = r_mem[r_addr];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  always_comb begin
    w_rdata = 32'd0;
    case (r_size)
      2'b00:   w_rdata = {{24{r_signed & w_b0[7]}}, w_b0};
      2'b01:   w_rdata = {{16{r_signed & w_b0[7]}}, w_b0, w_b1};
      2'b10:   w_rdata = {w_b0, w_b1, w_b2, w_b3};
      default: w_rdata = 32'd0;
    endcase
  end

  // Storage is deliberately not reset; only EXEC can commit a write.
  always_ff @(posedge i_clk) begin
    if (w_exec && r_we && !w_err) begin
      case (r_size)
        2'b00: r_mem[r_addr] <= r_wdata[7:0];
        2'b01: begin
          r_mem[r_addr] <= r_wdata[15:8];
          r_mem[w_a1]   <= r_wdata[7:0];
        end
        2'b10: begin
          r_mem[r_addr] <= r_wdata[31:24];
          r_mem[w_a1]   <= r_wdata[23:16];
          r_mem[w_a2]   <= r_wdata[15:8];
          r_mem[w_a3]   <= r_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_exec) begin
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (!r_we && !w_err) ? w_rdata : 32'd0;
    end
  end

`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] r_stat_loads;
  logic [15:0] r_stat_stores;
  logic [15:0] r_stat_errs;

  assign o_stat_loads  = r_stat_loads;
  assign o_stat_stores = r_stat_stores;
  assign o_stat_errs   = r_stat_errs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_loads  <= 16'd0;
      r_stat_stores <= 16'd0;
      r_stat_errs   <= 16'd0;
    end else if (w_exec) begin
      if (w_err) begin
        if (r_stat_errs != 16'hFFFF) r_stat_errs <= r_stat_errs + 16'd1;
      end else if (r_we) begin
        if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
      end else begin
        if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pa_risc_dmem_responder.sv
// tb/tb_pa_risc_dmem_responder.sv - scoreboard bench for pa_risc_dmem_responder
module tb_pa_risc_dmem_responder;
  localparam int DEPTH = 256;
  localparam int ADDR_W = 8;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  pa_risc_dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
`ifdef DMEM_RESPONDER_STATS_EN
    , .o_stat_loads(stat_loads), .o_stat_stores(stat_stores), .o_stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      n_rsp++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("latency", 32'(cyc - e.t_acc), 32'(WAIT_CYCLES + 2));
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                       input bit push, output int low);
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    low = 0;
    while (!req_ready && low < 40) begin
      low++;
      @(negedge clk);
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    if (push) sb.push_back('{erd, eerr, cyc});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic st(input logic [1:0] size, input logic [7:0] addr, input logic [31:0] d, input logic eerr);
    int low;
    issue(1'b1, size, 1'b0, addr, d, 32'd0, eerr, 1'b1, low);
    drain();
  endtask

  task automatic ld(input logic [1:0] size, input logic sgn, input logic [7:0] addr,
                    input logic [31:0] erd, input logic eerr);
    int low;
    issue(1'b0, size, sgn, addr, 32'd0, erd, eerr, 1'b1, low);
    drain();
  endtask

  initial begin
    int low;
    int n0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_err", {31'd0, rsp_err}, 32'd0);

    st(2'b10, 8'd44, 32'hDEADBEEF, 1'b0);
    ld(2'b00, 1'b1, 8'd47, 32'hFFFFFFEF, 1'b0);
    ld(2'b00, 1'b0, 8'd47, 32'h000000EF, 1'b0);
    ld(2'b01, 1'b1, 8'd46, 32'hFFFFBEEF, 1'b0);
    ld(2'b01, 1'b0, 8'd46, 32'h0000BEEF, 1'b0);
    ld(2'b10, 1'b0, 8'd44, 32'hDEADBEEF, 1'b0);

    st(2'b01, 8'd45, 32'h0000AAAA, 1'b1);
    ld(2'b10, 1'b0, 8'd46, 32'd0, 1'b1);
    ld(2'b11, 1'b0, 8'd0, 32'd0, 1'b1);
    ld(2'b10, 1'b0, 8'd254, 32'd0, 1'b1);
    st(2'b10, 8'd254, 32'h01020304, 1'b1);
    ld(2'b01, 1'b1, 8'd255, 32'd0, 1'b1);
    ld(2'b10, 1'b0, 8'd44, 32'hDEADBEEF, 1'b0);

    st(2'b00, 8'd45, 32'hFFFFFF11, 1'b0);
    ld(2'b10, 1'b0, 8'd44, 32'hDE11BEEF, 1'b0);

    st(2'b01, 8'd254, 32'h123481C3, 1'b0);
    ld(2'b01, 1'b1, 8'd254, 32'hFFFF81C3, 1'b0);
    ld(2'b00, 1'b0, 8'd255, 32'h000000C3, 1'b0);
    ld(2'b00, 1'b1, 8'd254, 32'hFFFFFF81, 1'b0);

    // Back-to-back: second request is held while the first is in flight.
    n0 = n_rsp;
    issue(1'b1, 2'b10, 1'b0, 8'd100, 32'hA1B2C3D4, 32'd0, 1'b0, 1'b1, low);
    issue(1'b0, 2'b10, 1'b0, 8'd100, 32'd0, 32'hA1B2C3D4, 1'b0, 1'b1, low);
    check("held_ready_low_cycles", 32'(low), 32'(WAIT_CYCLES + 2));
    drain();
    check("b2b_rsp_count", 32'(n_rsp - n0), 32'd2);

    // Reset during WAIT drops the in-flight store.
    st(2'b10, 8'd8, 32'hCAFEF00D, 1'b0);
    ld(2'b10, 1'b0, 8'd8, 32'hCAFEF00D, 1'b0);
    n0 = n_rsp;
    issue(1'b1, 2'b10, 1'b0, 8'd8, 32'h12345678, 32'd0, 1'b0, 1'b0, low);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    check("rst_mid_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (8) @(negedge clk);
    check("no_rsp_after_reset", 32'(n_rsp - n0), 32'd0);
    ld(2'b10, 1'b0, 8'd8, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_RESPONDER_STATS_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("stat_loads_rst", {16'd0, stat_loads}, 32'd0);
    check("stat_stores_rst", {16'd0, stat_stores}, 32'd0);
    check("stat_errs_rst", {16'd0, stat_errs}, 32'd0);
    st(2'b10, 8'd20, 32'h00C0FFEE, 1'b0);
    st(2'b00, 8'd24, 32'h0000007F, 1'b0);
    ld(2'b10, 1'b0, 8'd20, 32'h00C0FFEE, 1'b0);
    ld(2'b00, 1'b1, 8'd24, 32'h0000007F, 1'b0);
    ld(2'b01, 1'b0, 8'd22, 32'h0000FFEE, 1'b0);
    ld(2'b11, 1'b0, 8'd0, 32'd0, 1'b1);
    check("stat_loads", {16'd0, stat_loads}, 32'd3);
    check("stat_stores", {16'd0, stat_stores}, 32'd2);
    check("stat_errs", {16'd0, stat_errs}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pa_risc_dmem_responder.md
Name: pa_risc_dmem_responder

Overview:
Data-memory responder for the PA-RISC core's load/store path. It is a byte-addressed, big-endian memory that accepts one request at a time through a valid/ready handshake. Each request takes a programmable number of wait cycles, then the block returns exactly one response pulse. It lets the pipeline's memory stage be exercised against realistic latency, where the existing data memory is single-cycle.

Parameters:
DEPTH, 256, memory size in bytes.
ADDR_W, 8, request address width; must satisfy 2^ADDR_W >= DEPTH.
WAIT_CYCLES, 2, extra cycles between acceptance and response (0..15).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept; high only in IDLE.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
req_signed  input  1  loads: sign-extend byte/half; ignored for stores.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data, right-justified (byte = [7:0], half = [15:0]).
rsp_valid  output  1  one-cycle response pulse.
rsp_rdata  output  32  load data; 0 for stores and errors.
rsp_err  output  1  request rejected; qualified by rsp_valid.

Behaviour:
- Storage: Mem[0..DEPTH-1], 8 bits each. Big-endian: word at A is {Mem[A],Mem[A+1],Mem[A+2],Mem[A+3]}; half at A is {Mem[A],Mem[A+1]}. Contents are not cleared by reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid, the request is accepted and all req_* fields are latched. Next state is WAIT if WAIT_CYCLES>0, else EXEC.
  - WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Move to EXEC when it reaches 0.
  - EXEC: one cycle. The store is committed to Mem, or load data is captured into rsp_rdata. rsp_err is computed. Next state is RESP.
  - RESP: rsp_valid=1 for exactly this cycle. Next state is IDLE.
- Latency: accept edge to rsp_valid high is WAIT_CYCLES+2 cycles. Maximum throughput is one request per WAIT_CYCLES+3 cycles.
- req_ready is low in WAIT/EXEC/RESP. req_valid in those states is ignored; the initiator must hold it until accepted.
- Error conditions (rsp_err=1, no Mem write, rsp_rdata=0):
  - req_size=11.
  - Half at an odd address.
  - Word with addr[1:0]!=0.
  - Last byte of the access is at or beyond DEPTH.
- Loads:
  - Byte: {24{s&b[7]},b} where s=req_signed.
  - Half: {16{s&h[15]},h}.
  - Word: unmodified.
- Stores: write only the addressed bytes; other bytes are untouched. rsp_rdata=0.
- rsp_rdata and rsp_err hold their values after RESP until the next EXEC.
- Reset (asynchronous, any state): state goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Any in-flight request is dropped with no Mem write and no response. req_ready=1 once reset deasserts.

Optional Feature:
Macro: DMEM_RESPONDER_STATS_EN.
- Defined:
  - Adds outputs stat_loads[15:0], stat_stores[15:0] and stat_errs[15:0]. All three reset to 0.
  - In EXEC, exactly one counter increments: stat_errs for an errored request, otherwise stat_loads or stat_stores.
  - Counters saturate at 16'hFFFF.
- Not defined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- WAIT_CYCLES=2, store word 32'hDEADBEEF at 44 → rsp_valid 4 cycles after accept, rsp_err=0. Mem[44..47] = DE, AD, BE, EF.
- Loads after the above:
  - Signed byte at 47 → 32'hFFFFFFEF.
  - Unsigned byte at 47 → 32'h000000EF.
  - Signed half at 46 → 32'hFFFFBEEF.
  - Word at 44 → 32'hDEADBEEF.
- Half store at 45, word load at 46, size 11 at 0, word at 254 (DEPTH=256) → each gives rsp_err=1, rsp_rdata=0, Mem unchanged.
- Second request held with req_valid=1 during WAIT → req_ready=0 until RESP completes. Second request is accepted on the first IDLE cycle; exactly two rsp_valid pulses occur.
- Store word 32'h12345678 at 8, reset pulsed low in WAIT → no rsp_valid, Mem[8..11] unchanged, outputs 0. A following load from 8 returns the old value.
- With DMEM_RESPONDER_STATS_EN: 3 loads, 2 stores, 1 error → stat_loads=3, stat_stores=2, stat_errs=1. All three are 0 after reset.
